// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with flush/stall priority, a saturating
// bubble counter and combinational load-use hazard detection.
module id_ex_reg #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic             valid_i,
   input  logic             RegWrite_i,
   input  logic             MemtoReg_i,
   input  logic             MemRead_i,
   input  logic             MemWrite_i,
   input  logic             ALUSrc_i,
   input  logic             Branch_i,
   input  logic [1:0]       ALUOp_i,
   input  logic [31:0]      RS1data_i,
   input  logic [31:0]      RS2data_i,
   input  logic [31:0]      Imm_i,
   input  logic [31:0]      pc_i,
   input  logic [9:0]       funct_i,
   input  logic [4:0]       RS1addr_i,
   input  logic [4:0]       RS2addr_i,
   input  logic [4:0]       RDaddr_i,
   output logic             valid_o,
   output logic             RegWrite_o,
   output logic             MemtoReg_o,
   output logic             MemRead_o,
   output logic             MemWrite_o,
   output logic             ALUSrc_o,
   output logic             Branch_o,
   output logic [1:0]       ALUOp_o,
   output logic [31:0]      RS1data_o,
   output logic [31:0]      RS2data_o,
   output logic [31:0]      Imm_o,
   output logic [31:0]      pc_o,
   output logic [9:0]       funct_o,
   output logic [4:0]       RS1addr_o,
   output logic [4:0]       RS2addr_o,
   output logic [4:0]       RDaddr_o,
   output logic             load_use_o,
   output logic [CNT_W-1:0] bubble_cnt_o
);
   localparam int W = 162;
   logic [W-1:0] q, d;
   logic         bubble;
   // An invalid instruction still carries its data; only its control is squashed.
   assign d = flush_i ? '0 :
      {valid_i,
       {6{valid_i}} & {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i},
       valid_i ? ALUOp_i : 2'b00,
       RS1data_i, RS2data_i, Imm_i, pc_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i};
   assign bubble = flush_i | (~stall_i & ~valid_i);
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) q <= '0;
      else if (flush_i || !stall_i) q <= d;
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) bubble_cnt_o <= '0;
      else if (bubble && bubble_cnt_o != '1) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
   end
   assign {valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o,
           ALUOp_o, RS1data_o, RS2data_o, Imm_o, pc_o, funct_o,
           RS1addr_o, RS2addr_o, RDaddr_o} = q;
   assign load_use_o = valid_o & MemRead_o & (|RDaddr_o) &
                       ((RDaddr_o == RS1addr_i) | (RDaddr_o == RS2addr_i));
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: randomized and directed checks of id_ex_reg against a
// behavioural model of the pipeline register, counter and hazard flag.
module tb_id_ex_reg;
   typedef struct packed {
      logic        valid, regwrite, memtoreg, memread, memwrite, alusrc, branch;
      logic [1:0]  aluop;
      logic [31:0] rs1d, rs2d, imm, pc;
      logic [9:0]  funct;
      logic [4:0]  rs1a, rs2a, rda;
   } st_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   logic stall_i = 1'b0;
   logic flush_i = 1'b0;
   st_t  in = '0;
   st_t  got, got2, exp;
   logic load_use_o, load_use2;
   logic [15:0] cnt;
   logic [1:0]  cnt2;
   int   exp_cnt = 0, exp_cnt2 = 0;
   int   checks = 0, errors = 0;

   always #5 clk_i = ~clk_i;

   id_ex_reg dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
      .valid_i(in.valid), .RegWrite_i(in.regwrite), .MemtoReg_i(in.memtoreg),
      .MemRead_i(in.memread), .MemWrite_i(in.memwrite), .ALUSrc_i(in.alusrc),
      .Branch_i(in.branch), .ALUOp_i(in.aluop), .RS1data_i(in.rs1d), .RS2data_i(in.rs2d),
      .Imm_i(in.imm), .pc_i(in.pc), .funct_i(in.funct), .RS1addr_i(in.rs1a),
      .RS2addr_i(in.rs2a), .RDaddr_i(in.rda),
      .valid_o(got.valid), .RegWrite_o(got.regwrite), .MemtoReg_o(got.memtoreg),
      .MemRead_o(got.memread), .MemWrite_o(got.memwrite), .ALUSrc_o(got.alusrc),
      .Branch_o(got.branch), .ALUOp_o(got.aluop), .RS1data_o(got.rs1d), .RS2data_o(got.rs2d),
      .Imm_o(got.imm), .pc_o(got.pc), .funct_o(got.funct), .RS1addr_o(got.rs1a),
      .RS2addr_o(got.rs2a), .RDaddr_o(got.rda), .load_use_o(load_use_o), .bubble_cnt_o(cnt)
   );

   id_ex_reg #(.CNT_W(2)) dut2 (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
      .valid_i(in.valid), .RegWrite_i(in.regwrite), .MemtoReg_i(in.memtoreg),
      .MemRead_i(in.memread), .MemWrite_i(in.memwrite), .ALUSrc_i(in.alusrc),
      .Branch_i(in.branch), .ALUOp_i(in.aluop), .RS1data_i(in.rs1d), .RS2data_i(in.rs2d),
      .Imm_i(in.imm), .pc_i(in.pc), .funct_i(in.funct), .RS1addr_i(in.rs1a),
      .RS2addr_i(in.rs2a), .RDaddr_i(in.rda),
      .valid_o(got2.valid), .RegWrite_o(got2.regwrite), .MemtoReg_o(got2.memtoreg),
      .MemRead_o(got2.memread), .MemWrite_o(got2.memwrite), .ALUSrc_o(got2.alusrc),
      .Branch_o(got2.branch), .ALUOp_o(got2.aluop), .RS1data_o(got2.rs1d), .RS2data_o(got2.rs2d),
      .Imm_o(got2.imm), .pc_o(got2.pc), .funct_o(got2.funct), .RS1addr_o(got2.rs1a),
      .RS2addr_o(got2.rs2a), .RDaddr_o(got2.rda), .load_use_o(load_use2), .bubble_cnt_o(cnt2)
   );

   function automatic logic exp_lu();
      return exp.valid && exp.memread && exp.rda != 0 && (exp.rda == in.rs1a || exp.rda == in.rs2a);
   endfunction

   // Reference: one rising edge of the ID/EX register in terms of the priority rules.
   task automatic tick();
      @(posedge clk_i);
      if (rst_i) begin
         if (flush_i || (!stall_i && !in.valid)) begin
            exp_cnt  = exp_cnt  < 65535 ? exp_cnt + 1  : exp_cnt;
            exp_cnt2 = exp_cnt2 < 3     ? exp_cnt2 + 1 : exp_cnt2;
         end
         if (flush_i) exp = '0;
         else if (!stall_i) begin
            exp = in;
            if (!in.valid) {exp.regwrite, exp.memtoreg, exp.memread, exp.memwrite,
                            exp.alusrc, exp.branch, exp.aluop} = '0;
         end
      end
      #1;
   endtask

   task automatic rand_in();
      logic [191:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      in = r[161:0];
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      exp = '0; exp_cnt = 0; exp_cnt2 = 0;
      #1;
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic test_reset();
      in = '0; in.valid = 1'b1;
      #2;
      checks++;
      if (got !== '0 || cnt !== 16'd0 || load_use_o !== 1'b0) begin
         errors++; $display("FAIL reset: got=%h cnt=%0d lu=%b want all zero", got, cnt, load_use_o);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      in = '0; in.valid = 1'b1; in.rs1d = 32'hCAFE0001;
      tick();
      checks++;
      if (got !== exp || got.rs1d !== 32'hCAFE0001) begin
         errors++; $display("FAIL first_edge_after_reset: got=%h want=%h", got, exp);
      end
   endtask

   task automatic test_passthrough();
      in = '0; in.valid = 1'b1; in.regwrite = 1'b1; in.aluop = 2'b11; in.rs1d = 32'h1234;
      in.rs2d = 32'h55AA; in.funct = 10'h3FF; in.rda = 5'd7;
      tick();
      checks++;
      if (got.regwrite !== 1'b1 || got.aluop !== 2'b11 || got.rs1d !== 32'h1234 || got.valid !== 1'b1) begin
         errors++; $display("FAIL rtype_pass: rw=%b aluop=%b rs1d=%h v=%b want 1 11 1234 1",
                            got.regwrite, got.aluop, got.rs1d, got.valid);
      end
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rtype_all: got=%h want=%h", got, exp); end
   endtask

   task automatic test_load_use();
      in = '0; in.valid = 1'b1; in.memread = 1'b1; in.regwrite = 1'b1; in.rda = 5'd5; in.rs1a = 5'd1;
      tick();
      in = '0; in.valid = 1'b1; in.rs1a = 5'd9; in.rs2a = 5'd5;
      #1;
      checks++;
      if (load_use_o !== 1'b1) begin errors++; $display("FAIL load_use_rs2: got=%b want=1", load_use_o); end
      in.rs2a = 5'd6;
      #1;
      checks++;
      if (load_use_o !== 1'b0) begin errors++; $display("FAIL load_use_nomatch: got=%b want=0", load_use_o); end
      in = '0; in.valid = 1'b1; in.memread = 1'b1; in.rda = 5'd0;
      tick();
      in.rs1a = 5'd0; in.rs2a = 5'd0;
      #1;
      checks++;
      if (load_use_o !== 1'b0) begin errors++; $display("FAIL load_use_rd0: got=%b want=0", load_use_o); end
   endtask

   task automatic test_flush_stall();
      in = '0; in.valid = 1'b1; in.regwrite = 1'b1; in.aluop = 2'b10; in.rs1d = 32'hFFFF; in.rda = 5'd3;
      stall_i = 1'b1; flush_i = 1'b1;
      tick();
      stall_i = 1'b0; flush_i = 1'b0;
      checks++;
      if (got !== '0 || cnt !== 16'd1) begin
         errors++; $display("FAIL flush_stall: got=%h cnt=%0d want zero and cnt=1", got, cnt);
      end
   endtask

   task automatic test_stall();
      st_t held;
      in = '0; in.valid = 1'b1; in.memwrite = 1'b1; in.pc = 32'h400; in.imm = 32'h8;
      tick();
      held = got;
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_in();
         tick();
         checks++;
         if (got !== held || got !== exp || cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL stall_hold[%0d]: got=%h cnt=%0d want=%h cnt=%0d", i, got, cnt, held, exp_cnt);
         end
      end
      stall_i = 1'b0;
   endtask

   task automatic test_saturation();
      logic [1:0] seq [5];
      seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         rand_in();
         flush_i = i[0];
         in.valid = 1'b0;
         tick();
         checks++;
         if (cnt2 !== seq[i] || cnt2 !== 2'(exp_cnt2) || cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL saturate[%0d]: cnt2=%0d want=%0d cnt=%0d want=%0d", i, cnt2, seq[i], cnt, exp_cnt);
         end
      end
      flush_i = 1'b0;
   endtask

   task automatic test_async_reset();
      in = '0; in.valid = 1'b1; in.memread = 1'b1; in.rda = 5'd4; in.rs1a = 5'd4;
      tick();
      checks++;
      if (got.memread !== 1'b1 || load_use_o !== 1'b1) begin
         errors++; $display("FAIL async_setup: memread=%b lu=%b want 1 1", got.memread, load_use_o);
      end
      #2;
      rst_i = 1'b0;
      #1;
      checks++;
      if (got !== '0 || cnt !== 16'd0 || cnt2 !== 2'd0 || load_use_o !== 1'b0) begin
         errors++; $display("FAIL async_reset: got=%h cnt=%0d lu=%b want all zero", got, cnt, load_use_o);
      end
      exp = '0; exp_cnt = 0; exp_cnt2 = 0;
      stall_i = 1'b1; flush_i = 1'b1; in.valid = 1'b0;
      tick();
      tick();
      checks++;
      if (got !== '0 || cnt !== 16'd0) begin
         errors++; $display("FAIL reset_over_flush: got=%h cnt=%0d want zero", got, cnt);
      end
      @(negedge clk_i);
      rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
      rand_in(); in.valid = 1'b1;
      tick();
      checks++;
      if (got !== exp || cnt !== 16'd0) begin
         errors++; $display("FAIL post_reset_load: got=%h want=%h cnt=%0d", got, exp, cnt);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         rand_in();
         if ($urandom_range(1, 0) == 1) in.rs2a = exp.rda;
         stall_i = ($urandom_range(3, 0) == 0);
         flush_i = ($urandom_range(7, 0) == 0);
         #1;
         checks++;
         if (load_use_o !== exp_lu()) begin
            errors++; $display("FAIL rand_lu[%0d]: got=%b want=%b", i, load_use_o, exp_lu());
         end
         tick();
         checks++;
         if (got !== exp || cnt !== 16'(exp_cnt) || cnt2 !== 2'(exp_cnt2)) begin
            errors++; $display("FAIL rand[%0d]: got=%h want=%h cnt=%0d/%0d cnt2=%0d/%0d",
                               i, got, exp, cnt, exp_cnt, cnt2, exp_cnt2);
         end
      end
      stall_i = 1'b0; flush_i = 1'b0;
   endtask

   initial begin
      exp = '0;
      test_reset();
      test_passthrough();
      test_load_use();
      test_flush_stall();
      test_stall();
      test_saturation();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the bubble counter.
REQ-002 The block SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_i, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port stall_i, input, 1: hold all registered state this cycle.
REQ-005 The block SHALL have port flush_i, input, 1: load a bubble this cycle (branch taken).
REQ-006 The block SHALL have port valid_i, input, 1: ID-stage instruction valid.
REQ-007 The block SHALL have ports RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i, input, 1 each, and ALUOp_i, input, 2: control bundle from the decode control unit.
REQ-008 The block SHALL have ports RS1data_i, RS2data_i, Imm_i, pc_i, input, 32 each: operands, immediate, instruction PC.
REQ-009 The block SHALL have port funct_i, input, 10: {funct7, funct3}.
REQ-010 The block SHALL have ports RS1addr_i, RS2addr_i, RDaddr_i, input, 5 each: register addresses of the ID instruction.
REQ-011 The block SHALL have an _o output port of matching width for every port in REQ-006..REQ-010: registered EX-stage copies, including valid_o.
REQ-012 The block SHALL have port load_use_o, input-independent-of-clock output, 1: combinational load-use hazard flag.
REQ-013 The block SHALL have port bubble_cnt_o, output, CNT_W: count of bubbles inserted.

Function
REQ-014 Update priority at each rising clk_i SHALL be: reset > flush_i > stall_i > normal load.
REQ-015 On normal load, every _o register SHALL take its _i value on the same edge (latency 1 cycle).
REQ-016 On flush_i=1, valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, Branch_o, ALUSrc_o SHALL become 0 and ALUOp_o 2'b00; data/address registers SHALL become 0.
REQ-017 On stall_i=1 with flush_i=0, all registers including bubble_cnt_o SHALL hold.
REQ-018 When valid_i=0 on a normal load, control outputs SHALL load 0 regardless of the control inputs (bubble), data registers SHALL load their inputs.
REQ-019 load_use_o SHALL be 1 iff valid_o=1, MemRead_o=1, RDaddr_o!=0, and (RDaddr_o==RS1addr_i or RDaddr_o==RS2addr_i); 0 otherwise.
REQ-020 load_use_o SHALL be purely combinational from current registered state and RS1addr_i/RS2addr_i, with no dependence on stall_i or flush_i.
REQ-021 bubble_cnt_o SHALL increment by 1 on each edge where a bubble is loaded (flush_i=1, or normal load with valid_i=0).
REQ-022 bubble_cnt_o SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 Simultaneous flush_i and stall_i SHALL behave as flush (REQ-016) and SHALL increment the counter.

Reset
REQ-024 When rst_i=0, all outputs except load_use_o SHALL go to 0 immediately, independent of clk_i.
REQ-025 load_use_o SHALL be 0 while in reset, as a consequence of valid_o=0.
REQ-026 After rst_i rises, the first rising clk_i SHALL perform a normal update per REQ-014.
REQ-027 Reset asserted mid-stall or mid-flush SHALL override both, and no partial load SHALL survive.

Verification
REQ-028 The bench SHALL cover load-use: load lw RDaddr_i=5, MemRead_i=1, valid_i=1; next cycle RS2addr_i=5 -> load_use_o=1; with RDaddr=0 instead -> load_use_o=0.
REQ-029 The bench SHALL cover R-type pass-through: RegWrite_i=1, ALUOp_i=2'b11, RS1data_i=0x1234 -> one edge later RegWrite_o=1, ALUOp_o=2'b11, RS1data_o=0x1234, valid_o=1.
REQ-030 The bench SHALL cover flush+stall together with valid R-type inputs -> all control _o=0, valid_o=0, bubble_cnt_o increments 0->1.
REQ-031 The bench SHALL cover stall for 3 cycles while inputs change -> outputs unchanged and bubble_cnt_o unchanged.
REQ-032 The bench SHALL cover saturation: CNT_W=2 with 5 consecutive bubbles -> bubble_cnt_o sequence 1,2,3,3,3.
REQ-033 The bench SHALL cover async reset: assert rst_i=0 between clock edges with MemRead_o=1 -> all outputs 0 before the next edge and load_use_o=0.
